// File: rtl/cfg_sr_pkg.sv
// Shared sizes and static-loader state encoding for the configuration shift-register driver.
package cfg_sr_pkg;

  localparam int SIZESRSTAT_DEF = 88;
  localparam int SIZESRDYN_DEF  = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_LATCH = 2'b10
  } stat_state_t;

endpackage

// File: rtl/sr_serializer.sv
// Parallel-load MSB-first serializer: a bit shifted in cycle N appears on sdo/sr_en in cycle N+1.
// A load and a shift in the same cycle emit the first bit of the newly loaded word; count saturates at WIDTH.
module sr_serializer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_word,
  input  logic             shift,
  output logic             sdo,
  output logic             sr_en,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);

  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] src;
  logic [CW-1:0]    count;
  logic [CW-1:0]    cnt_base;

  // A load restarts the frame in the same cycle, so the shift sees the fresh word and a zero count.
  always_comb begin
    src      = load ? load_word : shreg;
    cnt_base = load ? '0 : count;
  end

  assign done = (count == FULL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      count <= '0;
      sdo   <= 1'b0;
      sr_en <= 1'b0;
    end else if (shift && (cnt_base < FULL)) begin
      sdo   <= src[WIDTH-1];
      sr_en <= 1'b1;
      shreg <= {src[WIDTH-2:0], 1'b0};
      count <= cnt_base + CW'(1);
    end else begin
      sdo   <= 1'b0;
      sr_en <= 1'b0;
      shreg <= src;
      count <= cnt_base;
    end
  end

endmodule

// File: rtl/cfg_sr_driver.sv
// Serialises dynamic/static detector config words behind the sequencing FSM; 1 cycle from phase to bit.
// One-entry dynamic holding buffer (dyn_ready = empty); stat_load is ignored while a static load is busy.
module cfg_sr_driver
  import cfg_sr_pkg::*;
#(
  parameter int SIZESRSTAT = SIZESRSTAT_DEF,
  parameter int SIZESRDYN  = SIZESRDYN_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  sel_dyn,
  input  logic                  sel_stat,
  input  logic                  en_fin,
  input  logic [SIZESRDYN-1:0]  dyn_word,
  input  logic                  dyn_valid,
  output logic                  dyn_ready,
  input  logic [SIZESRSTAT-1:0] stat_word,
  input  logic                  stat_load,
  output logic                  stat_busy,
  output logic                  sdo_dyn,
  output logic                  sr_en_dyn,
  output logic                  latch_dyn,
  output logic                  sdo_stat,
  output logic                  sr_en_stat,
  output logic                  latch_stat,
  output logic                  underrun,
  output logic                  short_frame
);

  logic                 dyn_phase;
  logic                 dyn_phase_q;
  logic                 start;
  logic                 accept;
  logic                 hold_full;
  logic [SIZESRDYN-1:0] hold_word;
  logic [SIZESRDYN-1:0] last_word;
  logic [SIZESRDYN-1:0] dyn_load_word;
  logic                 dyn_done;

  assign dyn_phase     = sel_dyn & ~en_fin;
  assign start         = dyn_phase & ~dyn_phase_q;
  assign dyn_ready     = ~hold_full;
  assign accept        = dyn_valid & dyn_ready;
  // With nothing queued the previous frame is repeated so the detector keeps a known setting.
  assign dyn_load_word = hold_full ? hold_word : last_word;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dyn_phase_q <= 1'b0;
      hold_full   <= 1'b0;
      hold_word   <= '0;
      last_word   <= '0;
      underrun    <= 1'b0;
      latch_dyn   <= 1'b0;
      short_frame <= 1'b0;
    end else begin
      dyn_phase_q <= dyn_phase;
      underrun    <= start & ~hold_full;
      latch_dyn   <= sel_stat;
      short_frame <= sel_stat & ~dyn_done;
      if (start && hold_full) begin
        last_word <= hold_word;
        hold_full <= 1'b0;
      end else if (accept) begin
        hold_word <= dyn_word;
        hold_full <= 1'b1;
      end
    end
  end

  sr_serializer #(.WIDTH(SIZESRDYN)) u_dyn_ser (
    .clk       (CLK),
    .rst       (RST),
    .load      (start),
    .load_word (dyn_load_word),
    .shift     (dyn_phase),
    .sdo       (sdo_dyn),
    .sr_en     (sr_en_dyn),
    .done      (dyn_done)
  );

  stat_state_t state;
  stat_state_t state_next;
  logic        stat_capture;
  logic        stat_shift;
  logic        stat_done;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Static bits only move in the idle window between dynamic frames.
  always_comb begin
    state_next   = state;
    stat_capture = 1'b0;
    stat_shift   = 1'b0;
    stat_busy    = 1'b1;
    latch_stat   = 1'b0;
    unique case (state)
      S_IDLE: begin
        stat_busy    = 1'b0;
        stat_capture = stat_load;
        if (stat_load) begin
          state_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        stat_shift = ~sel_dyn & ~sel_stat;
        if (stat_done) begin
          state_next = S_LATCH;
        end
      end
      S_LATCH: begin
        latch_stat = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  sr_serializer #(.WIDTH(SIZESRSTAT)) u_stat_ser (
    .clk       (CLK),
    .rst       (RST),
    .load      (stat_capture),
    .load_word (stat_word),
    .shift     (stat_shift),
    .sdo       (sdo_stat),
    .sr_en     (sr_en_stat),
    .done      (stat_done)
  );

endmodule

// File: tb/tb_cfg_sr_driver.sv
// Bench for cfg_sr_driver: queue-based reference model compared every cycle, plus directed frame checks.
module tb_cfg_sr_driver;

  localparam int DYN  = 16;
  localparam int STAT = 88;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic            sel_dyn = 1'b0, sel_stat = 1'b0, en_fin = 1'b0;
  logic [DYN-1:0]  dyn_word = '0;
  logic            dyn_valid = 1'b0;
  logic            dyn_ready;
  logic [STAT-1:0] stat_word = '0;
  logic            stat_load = 1'b0;
  logic            stat_busy;
  logic            sdo_dyn, sr_en_dyn, latch_dyn;
  logic            sdo_stat, sr_en_stat, latch_stat;
  logic            underrun, short_frame;

  cfg_sr_driver dut (
    .CLK(CLK), .RST(RST), .sel_dyn(sel_dyn), .sel_stat(sel_stat), .en_fin(en_fin),
    .dyn_word(dyn_word), .dyn_valid(dyn_valid), .dyn_ready(dyn_ready),
    .stat_word(stat_word), .stat_load(stat_load), .stat_busy(stat_busy),
    .sdo_dyn(sdo_dyn), .sr_en_dyn(sr_en_dyn), .latch_dyn(latch_dyn),
    .sdo_stat(sdo_stat), .sr_en_stat(sr_en_stat), .latch_stat(latch_stat),
    .underrun(underrun), .short_frame(short_frame)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: words as queues of bits, frames as "pop one bit per shifting cycle".
  logic [DYN-1:0] bufq[$];
  logic [DYN-1:0] last_m = '0;
  bit             bitq[$];
  bit             sq[$];
  int             sent = 0;
  int             smode = 0;
  bit             prev_phase = 0;
  bit             prev_window = 0;
  bit e_sdo_dyn = 0, e_en_dyn = 0, e_latch_dyn = 0, e_under = 0, e_short = 0;
  bit e_sdo_stat = 0, e_en_stat = 0;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      bufq.delete(); bitq.delete(); sq.delete();
      last_m = '0; sent = 0; smode = 0; prev_phase = 0;
      e_sdo_dyn = 0; e_en_dyn = 0; e_latch_dyn = 0; e_under = 0; e_short = 0;
      e_sdo_stat = 0; e_en_stat = 0;
    end else begin
      bit dp, st, acc, win;
      logic [DYN-1:0] w;
      dp  = sel_dyn && !en_fin;
      st  = dp && !prev_phase;
      acc = dyn_valid && (bufq.size() == 0);
      win = !sel_dyn && !sel_stat;
      e_latch_dyn = sel_stat;
      e_short     = sel_stat && (sent != DYN);
      e_under     = 0;
      if (st) begin
        if (bufq.size() != 0) begin
          w = bufq.pop_front();
          last_m = w;
        end else begin
          w = last_m;
          e_under = 1;
        end
        bitq.delete();
        for (int i = DYN - 1; i >= 0; i--) bitq.push_back(w[i]);
        sent = 0;
      end
      if (acc) bufq.push_back(dyn_word);
      if (dp && bitq.size() != 0) begin
        e_sdo_dyn = bitq.pop_front();
        e_en_dyn  = 1;
        sent++;
      end else begin
        e_sdo_dyn = 0;
        e_en_dyn  = 0;
      end
      prev_phase  = dp;
      prev_window = win;
      e_sdo_stat = 0;
      e_en_stat  = 0;
      case (smode)
        0: if (stat_load) begin
             sq.delete();
             for (int i = STAT - 1; i >= 0; i--) sq.push_back(stat_word[i]);
             smode = 1;
           end
        1: if (sq.size() == 0) smode = 2;
           else if (win) begin
             e_sdo_stat = sq.pop_front();
             e_en_stat  = 1;
           end
        default: smode = 0;
      endcase
    end
  end

  always @(negedge CLK) begin
    chk("sdo_dyn",     32'(sdo_dyn),     32'(e_sdo_dyn));
    chk("sr_en_dyn",   32'(sr_en_dyn),   32'(e_en_dyn));
    chk("latch_dyn",   32'(latch_dyn),   32'(e_latch_dyn));
    chk("underrun",    32'(underrun),    32'(e_under));
    chk("short_frame", 32'(short_frame), 32'(e_short));
    chk("dyn_ready",   32'(dyn_ready),   32'(bufq.size() == 0));
    chk("sdo_stat",    32'(sdo_stat),    32'(e_sdo_stat));
    chk("sr_en_stat",  32'(sr_en_stat),  32'(e_en_stat));
    chk("latch_stat",  32'(latch_stat),  32'(smode == 2));
    chk("stat_busy",   32'(stat_busy),   32'(smode != 0));
  end

  // Event monitor feeding the hand-computed scenario checks.
  int cyc = 0, en_cnt = 0, last_en_cyc = 0, latch_cnt = 0, latch_cyc = 0;
  int under_cnt = 0, short_cnt = 0, short_cyc = 0, ready_low = 0;
  int sen_cnt = 0, last_sen_cyc = 0, sones = 0, sone_at = 0, wviol = 0;
  int slatch = 0, slatch_cyc = 0;
  logic [DYN-1:0] cap = '0;

  always @(negedge CLK) begin
    cyc++;
    if (sr_en_dyn) begin en_cnt++; cap = {cap[DYN-2:0], sdo_dyn}; last_en_cyc = cyc; end
    if (latch_dyn) begin latch_cnt++; latch_cyc = cyc; end
    if (underrun) under_cnt++;
    if (short_frame) begin short_cnt++; short_cyc = cyc; end
    if (!dyn_ready) ready_low++;
    if (sr_en_stat) begin
      sen_cnt++; last_sen_cyc = cyc;
      if (sdo_stat) begin sones++; sone_at = sen_cnt; end
      if (!prev_window) wviol++;
    end
    if (latch_stat) begin slatch++; slatch_cyc = cyc; end
  end

  bit rnd = 0;

  task automatic tick();
    if (rnd) begin
      dyn_valid = ($urandom_range(0, 3) == 0);
      dyn_word  = DYN'($urandom);
      stat_load = ($urandom_range(0, 40) == 0);
      stat_word = STAT'({$urandom, $urandom, $urandom});
    end
    @(negedge CLK);
  endtask

  task automatic frame(input int nd, input int nw, input int ni, input bit offer);
    for (int i = 0; i < nd; i++) begin
      sel_dyn = 1; en_fin = 0; sel_stat = 0;
      if (offer && i == 0) begin dyn_valid = 1; dyn_word = 16'h3C5A; end
      else if (!rnd) dyn_valid = 0;
      tick();
    end
    sel_dyn = 0; sel_stat = 1; en_fin = 0;
    if (!rnd) dyn_valid = 0;
    tick();
    for (int i = 0; i < nw; i++) begin sel_dyn = 1; en_fin = 1; sel_stat = 0; tick(); end
    for (int i = 0; i < ni; i++) begin sel_dyn = 0; en_fin = 0; sel_stat = 0; tick(); end
    sel_dyn = 0; en_fin = 0; sel_stat = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_en, b_latch, b_under, b_short, b_ready, b_sen, b_sones, b_slatch;
    @(negedge CLK);
    chk("rst_dyn_ready", 32'(dyn_ready), 32'd1);
    chk("rst_sr_en_dyn", 32'(sr_en_dyn), 32'd0);
    chk("rst_stat_busy", 32'(stat_busy), 32'd0);
    @(negedge CLK);
    RST = 0;

    // Frame 1: queued word shifts MSB-first.
    dyn_valid = 1; dyn_word = 16'hA5C3; tick(); dyn_valid = 0;
    b_en = en_cnt; b_latch = latch_cnt; b_under = under_cnt; b_short = short_cnt;
    frame(16, 2, 3, 0);
    chk("f1_bits", 32'(cap), 32'h0000A5C3);
    chk("f1_en_count", 32'(en_cnt - b_en), 32'd16);
    chk("f1_latch_count", 32'(latch_cnt - b_latch), 32'd1);
    chk("f1_latch_after_last_bit", 32'(latch_cyc - last_en_cyc), 32'd1);
    chk("f1_underrun", 32'(under_cnt - b_under), 32'd0);
    chk("f1_short", 32'(short_cnt - b_short), 32'd0);
    chk("model_last_word", 32'(last_m), 32'h0000A5C3);

    // Frame 2: nothing queued, previous word repeats.
    b_under = under_cnt; b_ready = ready_low; cap = '0;
    frame(16, 2, 3, 0);
    chk("f2_underrun", 32'(under_cnt - b_under), 32'd1);
    chk("f2_bits", 32'(cap), 32'h0000A5C3);
    chk("f2_ready_low", 32'(ready_low - b_ready), 32'd0);

    // Frame 3: word offered in the start cycle lands in the buffer only.
    b_under = under_cnt; cap = '0;
    frame(16, 2, 3, 1);
    chk("f3_underrun", 32'(under_cnt - b_under), 32'd1);
    chk("f3_bits", 32'(cap), 32'h0000A5C3);
    chk("f3_buffer_full", 32'(dyn_ready), 32'd0);
    b_under = under_cnt;
    frame(16, 2, 3, 0);
    chk("f4_bits", 32'(cap), 32'h00003C5A);
    chk("f4_underrun", 32'(under_cnt - b_under), 32'd0);

    // Short frame: latch after 10 bits.
    b_en = en_cnt; b_latch = latch_cnt; b_short = short_cnt;
    frame(10, 2, 3, 0);
    chk("short_en_count", 32'(en_cnt - b_en), 32'd10);
    chk("short_count", 32'(short_cnt - b_short), 32'd1);
    chk("short_latch_count", 32'(latch_cnt - b_latch), 32'd1);
    chk("short_same_cycle", 32'(short_cyc), 32'(latch_cyc));

    // Static load of 88'h1 interleaved with dynamic frames.
    b_sen = sen_cnt; b_sones = sones; b_slatch = slatch;
    stat_word = 88'h1; stat_load = 1; tick(); stat_load = 0;
    for (int f = 0; f < 3; f++) frame(16, 1, 6, 0);
    chk("stat_busy_mid", 32'(stat_busy), 32'd1);
    stat_word = '1; stat_load = 1; tick(); stat_load = 0;
    for (int f = 0; f < 40 && stat_busy; f++) frame(16, 1, 6, 0);
    tick(); tick();
    chk("stat_done_in_time", 32'(stat_busy), 32'd0);
    chk("stat_en_count", 32'(sen_cnt - b_sen), 32'd88);
    chk("stat_ones", 32'(sones - b_sones), 32'd1);
    chk("stat_one_position", 32'(sone_at - b_sen), 32'd88);
    chk("stat_window_violations", 32'(wviol), 32'd0);
    chk("stat_latch_count", 32'(slatch - b_slatch), 32'd1);
    chk("stat_latch_after_last", 32'(slatch_cyc - last_sen_cyc), 32'd1);

    // Reset in the middle of a dynamic frame.
    dyn_valid = 1; dyn_word = 16'h0FF0; tick(); dyn_valid = 0;
    b_latch = latch_cnt;
    for (int i = 0; i < 8; i++) begin sel_dyn = 1; en_fin = 0; tick(); end
    chk("rst_mid_shifting", 32'(sr_en_dyn), 32'd1);
    #2 RST = 1;
    #1;
    chk("rst_mid_sr_en_dyn", 32'(sr_en_dyn), 32'd0);
    chk("rst_mid_sdo_dyn", 32'(sdo_dyn), 32'd0);
    chk("rst_mid_dyn_ready", 32'(dyn_ready), 32'd1);
    chk("rst_mid_latch_dyn", 32'(latch_dyn), 32'd0);
    sel_dyn = 0;
    @(negedge CLK);
    RST = 0;
    for (int i = 0; i < 4; i++) tick();
    chk("rst_mid_no_latch", 32'(latch_cnt - b_latch), 32'd0);

    // Randomized frames, valid traffic and static loads against the model.
    rnd = 1;
    for (int f = 0; f < 250; f++)
      frame($urandom_range(0, 20), $urandom_range(0, 3), $urandom_range(0, 6), 0);
    rnd = 0; dyn_valid = 0; stat_load = 0;
    for (int i = 0; i < 4; i++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
